rv32im_mul_seq: RTL and testbench

Parametrised sequential multiplier for the RV32M/RV64M MUL, MULH, MULHSU and MULHU instructions.
- Replaces the fixed radix-2, unsigned-only, full-product multiplier in the execute stage.
- Adds a per-operation signedness mode, a configurable number of multiplier bits retired per cycle, and XLEN-wide result selection.
- Uses the same start/busy/valid handshake toward the execute-stage sequencer.

---
 rtl/rv32im_mul_seq.sv | 134 +++++++++++++
 tb/tb_rv32im_mul_seq.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/rv32im_mul_seq.sv
// rv32im_mul_seq: sequential shift-add multiplier for MUL/MULH/MULHSU/MULHU.
// Operands are reduced to magnitudes at start. RUN retires BITS_PER_CYCLE
// multiplier bits per cycle into a 2*XLEN accumulator. FIX restores the
// sign and selects the low or high result word.
// Optional feature: define RV32IM_MUL_EARLY_OUT_EN to leave RUN as soon as
// the remaining multiplier bits are all zero (data-dependent latency).
module rv32im_mul_seq #(
   parameter int XLEN           = 32,
   parameter int BITS_PER_CYCLE = 1
) (
   input  logic            clk_i,
   input  logic            reset_i,
   input  logic            start_i,
   input  logic [1:0]      mode_i,
   input  logic [XLEN-1:0] operand1_i,
   input  logic [XLEN-1:0] operand2_i,
   output logic            busy_o,
   output logic            valid_o,
   output logic [XLEN-1:0] result_o
);

   localparam int N = XLEN / BITS_PER_CYCLE;

   typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

   state_t              state, state_next;
   logic [1:0]          mode;
   logic                sign;
   logic [2*XLEN-1:0]   mcand, acc, partial, prod;
   logic [XLEN-1:0]     mplier, mag1, mag2;
   logic                neg1, neg2;
   logic                last;

`ifdef RV32IM_MUL_EARLY_OUT_EN
   localparam bit EARLY_OUT = 1'b1;

   // RUN ends on the cycle that shifts the last nonzero multiplier bit out
   always_comb begin
      last = ((mplier >> BITS_PER_CYCLE) == '0);
   end
`else
   localparam bit EARLY_OUT = 1'b0;
   localparam int CW = $clog2(N) + 1;

   logic [CW-1:0] cnt;

   // Count RUN cycles; cleared on every accepted start
   always_ff @(posedge clk_i) begin
      if (reset_i)
         cnt <= '0;
      else if (state == IDLE && start_i)
         cnt <= '0;
      else if (state == RUN)
         cnt <= cnt + CW'(1);
   end

   always_comb begin
      last = (cnt == CW'(N - 1));
   end
`endif

   // Operand conditioning: rs1 is signed for MULH/MULHSU, rs2 only for MULH
   always_comb begin
      neg1 = ((mode_i == 2'b01) || (mode_i == 2'b10)) && operand1_i[XLEN-1];
      neg2 = (mode_i == 2'b01) && operand2_i[XLEN-1];
      mag1 = neg1 ? (~operand1_i + XLEN'(1)) : operand1_i;
      mag2 = neg2 ? (~operand2_i + XLEN'(1)) : operand2_i;
   end

   // Partial product of this cycle's multiplier digit and the signed-corrected product
   always_comb begin
      partial = mcand * {{(2*XLEN-BITS_PER_CYCLE){1'b0}}, mplier[BITS_PER_CYCLE-1:0]};
      prod    = sign ? (~acc + (2*XLEN)'(1)) : acc;
   end

   // State register
   always_ff @(posedge clk_i) begin
      if (reset_i)
         state <= IDLE;
      else
         state <= state_next;
   end

   // Next-state logic; a start is only seen in IDLE, so busy starts are dropped
   always_comb begin
      state_next = state;
      case (state)
         IDLE: if (start_i) state_next = (EARLY_OUT && mag2 == '0) ? FIX : RUN;
         RUN:  if (last)    state_next = FIX;
         FIX:               state_next = IDLE;
         default:           state_next = IDLE;
      endcase
   end

   // FSM outputs: an operation is in flight through RUN and FIX
   always_comb begin
      busy_o = (state != IDLE);
   end

   // Datapath: load at start, shift-add in RUN, sign fix and word select in FIX
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         mode     <= '0;
         sign     <= 1'b0;
         mcand    <= '0;
         mplier   <= '0;
         acc      <= '0;
         result_o <= '0;
         valid_o  <= 1'b0;
      end else begin
         case (state)
            IDLE: if (start_i) begin
               mode    <= mode_i;
               sign    <= neg1 ^ neg2;
               mcand   <= {{XLEN{1'b0}}, mag1};
               mplier  <= mag2;
               acc     <= '0;
               valid_o <= 1'b0;
            end
            RUN: begin
               acc    <= acc + partial;
               mcand  <= mcand << BITS_PER_CYCLE;
               mplier <= mplier >> BITS_PER_CYCLE;
            end
            FIX: begin
               result_o <= (mode == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
               valid_o  <= 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_rv32im_mul_seq.sv
// tb_rv32im_mul_seq: scoreboard bench with two instances (1 and 4 bits/cycle).
// Expected result and latency are queued when a start is accepted and
// checked when the instance finishes an operation.
module tb_rv32im_mul_seq;

   logic        clk = 1'b0;
   logic        reset;
   logic [1:0]  start, busy, valid;
   logic [1:0]  mode [2];
   logic [31:0] op1  [2];
   logic [31:0] op2  [2];
   logic [31:0] res  [2];

   typedef struct {
      logic [31:0] res;
      int          start_cyc;
      int          lat;
   } exp_t;

   exp_t        q0[$];
   exp_t        q1[$];
   int          cyc = 0;
   int          n_cmp = 0;
   int          n_bad = 0;
   logic [1:0]  busy_prev = 2'b00;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   rv32im_mul_seq #(.XLEN(32), .BITS_PER_CYCLE(1)) u_dut1 (
      .clk_i(clk), .reset_i(reset), .start_i(start[0]), .mode_i(mode[0]),
      .operand1_i(op1[0]), .operand2_i(op2[0]),
      .busy_o(busy[0]), .valid_o(valid[0]), .result_o(res[0]));

   rv32im_mul_seq #(.XLEN(32), .BITS_PER_CYCLE(4)) u_dut4 (
      .clk_i(clk), .reset_i(reset), .start_i(start[1]), .mode_i(mode[1]),
      .operand1_i(op1[1]), .operand2_i(op2[1]),
      .busy_o(busy[1]), .valid_o(valid[1]), .result_o(res[1]));

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
      n_cmp++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h (t=%0t)", tag, got, want, $time);
      end
   endtask

   // Reference: sign/zero-extend to 64 bits, product is exact mod 2^64
   function automatic logic [31:0] ref_mul(input logic [1:0] m, input logic [31:0] a, input logic [31:0] b);
      logic [63:0] ea, eb, p;
      ea = (m == 2'b01 || m == 2'b10) ? {{32{a[31]}}, a} : {32'h0, a};
      eb = (m == 2'b01) ? {{32{b[31]}}, b} : {32'h0, b};
      p  = ea * eb;
      return (m == 2'b00) ? p[31:0] : p[63:32];
   endfunction

   function automatic int ref_lat(input int k, input logic [1:0] m, input logic [31:0] b);
      int bpc = (k == 1) ? 4 : 1;
`ifdef RV32IM_MUL_EARLY_OUT_EN
      logic [31:0] mg;
      int          w;
      mg = (m == 2'b01 && b[31]) ? -b : b;
      w  = 0;
      for (int i = 0; i < 32; i++) if (mg[i]) w = i + 1;
      if (w == 0) return 1;
      return (w + bpc - 1) / bpc + 1;
`else
      if (m == 2'b11 && b == 32'h0) return 32 / bpc + 1;
      return 32 / bpc + 1;
`endif
   endfunction

   function automatic int qsize(input int k);
      return (k == 0) ? q0.size() : q1.size();
   endfunction

   // Completion monitor: valid rising out of a busy cycle marks a finished op
   always @(negedge clk) begin : mon
      exp_t e;
      for (int k = 0; k < 2; k++) begin
         if (!reset && valid[k] && busy_prev[k]) begin
            check("busy_with_valid", {63'h0, busy[k]}, 64'h0);
            if (qsize(k) == 0)
               check("spurious_valid", {63'h0, valid[k]}, 64'h0);
            else begin
               e = (k == 0) ? q0.pop_front() : q1.pop_front();
               check((k == 0) ? "result_b1" : "result_b4", {32'h0, res[k]}, {32'h0, e.res});
               check((k == 0) ? "latency_b1" : "latency_b4", 64'(cyc - e.start_cyc), 64'(e.lat));
            end
         end
         busy_prev[k] <= busy[k];
      end
   end

   // Called at a negedge; queues the expectation only if the start will be accepted
   task automatic issue(input int k, input logic [1:0] m, input logic [31:0] a, input logic [31:0] b);
      exp_t e;
      start[k] = 1'b1;
      mode[k]  = m;
      op1[k]   = a;
      op2[k]   = b;
      if (!busy[k]) begin
         e.res       = ref_mul(m, a, b);
         e.start_cyc = cyc + 1;
         e.lat       = ref_lat(k, m, b);
         if (k == 0) q0.push_back(e); else q1.push_back(e);
      end
      @(negedge clk);
      start[k] = 1'b0;
   endtask

   task automatic wait_done(input int k);
      for (int i = 0; i < 200; i++) begin
         if (qsize(k) == 0) break;
         @(negedge clk);
      end
      if (qsize(k) != 0) begin
         check("timeout", 64'(qsize(k)), 64'h0);
         if (k == 0) q0.delete(); else q1.delete();
      end
   endtask

   task automatic run_dir(input int k, input logic [1:0] m, input logic [31:0] a, input logic [31:0] b);
      issue(k, m, a, b);
      wait_done(k);
      repeat (2) @(negedge clk);
      check("hold_valid", {63'h0, valid[k]}, 64'h1);
      check("hold_result", {32'h0, res[k]}, {32'h0, ref_mul(m, a, b)});
   endtask

   initial begin
      reset = 1'b1;
      start = 2'b00;
      for (int k = 0; k < 2; k++) begin
         mode[k] = 2'b00;
         op1[k]  = 32'h0;
         op2[k]  = 32'h0;
      end
      repeat (3) @(negedge clk);
      reset = 1'b0;
      repeat (3) @(negedge clk);
      for (int k = 0; k < 2; k++) begin
         check("rst_busy",   {63'h0, busy[k]},  64'h0);
         check("rst_valid",  {63'h0, valid[k]}, 64'h0);
         check("rst_result", {32'h0, res[k]},   64'h0);
      end

      // Directed, 1 bit/cycle
      run_dir(0, 2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF);
      run_dir(0, 2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF);
      run_dir(0, 2'b01, 32'h80000000, 32'h80000000);
      run_dir(0, 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF);
      run_dir(0, 2'b10, 32'hFFFFFFFF, 32'hFFFFFFFF);
      run_dir(0, 2'b00, 32'hFFFFFFFD, 32'h00000007);
      run_dir(0, 2'b00, 32'h12345678, 32'h00000003);
      run_dir(0, 2'b00, 32'hDEADBEEF, 32'h00000000);

      // Random and corner operands, 4 bits/cycle
      for (int i = 0; i < 16; i++)
         run_dir(1, 2'(i), $urandom, $urandom);
      run_dir(1, 2'b01, 32'h80000000, 32'h7FFFFFFF);
      run_dir(1, 2'b10, 32'h80000000, 32'hFFFFFFFF);

      // Back-to-back: each new start lands on the first valid cycle
      issue(1, 2'b01, $urandom, $urandom);
      for (int j = 0; j < 4; j++) begin
         for (int t = 0; t < 50 && !valid[1]; t++) @(negedge clk);
         issue(1, 2'(j), $urandom, $urandom);
      end
      wait_done(1);

      // A start during RUN must not disturb the in-flight operation
      issue(0, 2'b00, 32'h00001234, 32'h00005678);
      repeat (5) @(negedge clk);
      issue(0, 2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF);
      wait_done(0);
      repeat (2) @(negedge clk);
      check("ignored_start", {32'h0, res[0]}, {32'h0, ref_mul(2'b00, 32'h00001234, 32'h00005678)});

      // Reset mid-RUN aborts with no later valid pulse
      issue(0, 2'b01, 32'hCAFEBABE, 32'h8BADF00D);
      issue(1, 2'b11, 32'hCAFEBABE, 32'h8BADF00D);
      repeat (2) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
         check("abort_busy",  {63'h0, busy[k]},  64'h0);
         check("abort_valid", {63'h0, valid[k]}, 64'h0);
      end
      q0.delete();
      q1.delete();
      reset = 1'b0;
      repeat (40) @(negedge clk);
      for (int k = 0; k < 2; k++)
         check("no_valid_after_abort", {63'h0, valid[k]}, 64'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

endmodule
